// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC time-set controller: FSM state encoding,
// BCD field widths, wrap limits and BCD increment helpers for the edited time.
// No ports (package).
// -----------------------------------------------------------------------------
package rtc_pkg;

    localparam int H10_W   = 2;   // tens-of-hours digit width (0..2)
    localparam int DIG_W   = 4;   // every other BCD digit
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [H10_W-1:0] h10;
        logic [DIG_W-1:0] h1;
    } hours_t;

    typedef struct packed {
        logic [DIG_W-1:0] m10;
        logic [DIG_W-1:0] m1;
    } mins_t;

    // Hours +1 in BCD, wrapping HR_MAX back to 00.
    function automatic hours_t bcd_inc_hours(input hours_t h);
        hours_t r;
        if ((int'(h.h10) * 10 + int'(h.h1)) >= HR_MAX) begin
            r = '0;
        end else if (h.h1 == DIG_W'(9)) begin
            r.h10 = h.h10 + 1'b1;
            r.h1  = '0;
        end else begin
            r.h10 = h.h10;
            r.h1  = h.h1 + 1'b1;
        end
        return r;
    endfunction

    // Minutes +1 in BCD, wrapping MIN_MAX back to 00.
    function automatic mins_t bcd_inc_mins(input mins_t m);
        mins_t r;
        if ((int'(m.m10) * 10 + int'(m.m1)) >= MIN_MAX) begin
            r = '0;
        end else if (m.m1 == DIG_W'(9)) begin
            r.m10 = m.m10 + 1'b1;
            r.m1  = '0;
        end else begin
            r.m10 = m.m10;
            r.m1  = m.m1 + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// rtc_set_ctrl_if
// Time bus between the set controller and the time counter.
//   cur_*     : live BCD time, counter -> controller
//   set_*     : edited BCD time, controller -> counter
//   load_o    : one-cycle load strobe, controller -> counter
//   run_en_o  : counter advance enable, controller -> counter
// Modports: master = set controller side, slave = time counter side.
// -----------------------------------------------------------------------------
interface rtc_set_ctrl_if;
    import rtc_pkg::*;

    logic [H10_W-1:0] cur_hours_10_i;
    logic [DIG_W-1:0] cur_hours_1_i;
    logic [DIG_W-1:0] cur_min_10_i;
    logic [DIG_W-1:0] cur_min_1_i;

    logic [H10_W-1:0] set_hours_10_o;
    logic [DIG_W-1:0] set_hours_1_o;
    logic [DIG_W-1:0] set_min_10_o;
    logic [DIG_W-1:0] set_min_1_o;

    logic             load_o;
    logic             run_en_o;

    modport master (
        input  cur_hours_10_i, cur_hours_1_i, cur_min_10_i, cur_min_1_i,
        output set_hours_10_o, set_hours_1_o, set_min_10_o, set_min_1_o,
        output load_o, run_en_o
    );

    modport slave (
        output cur_hours_10_i, cur_hours_1_i, cur_min_10_i, cur_min_1_i,
        input  set_hours_10_o, set_hours_1_o, set_min_10_o, set_min_1_o,
        input  load_o, run_en_o
    );

endinterface

// File: rtl/rtc_set_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// 2-flop synchroniser, level debouncer and rising-edge press pulse for one
// raw push button.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button, active-high
//   press_o : one-cycle pulse on each accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 200000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             arm_q, arm_d;
    logic [1:0]       flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        meta_d  = btn_i;
        sync_d  = meta_q;
        prev_d  = level_q;
        // flush_q[1] marks the first cycle sync_q carries a post-reset sample.
        flush_d = {flush_q[0], 1'b1};
        // Presses are only honoured once the button has been seen released
        // after reset, so a button held through reset stays silent.
        arm_d   = arm_q | (flush_q[1] & ~sync_q);
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= 1'b0;
            flush_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            arm_q   <= arm_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = level_q & ~prev_q & arm_q;

endmodule

// File: rtl/rtc_set_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_set_ctrl
// Two-button time-set controller for an HH:MM real-time clock.
// Mode steps RUN -> SET_HR -> SET_MIN -> RUN (loading the edited time);
// inc advances the field being edited. Idle timeout aborts an edit without load.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   btn_mode_i, btn_inc_i  : raw buttons
//   tbus (master)          : cur_* in, set_*/load_o/run_en_o out
//   blank_o                : per-digit blank mask {h10,h1,m10,m1}
//   state_o                : current FSM state
// -----------------------------------------------------------------------------
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 10000000,
    parameter int unsigned DEBOUNCE_CYC   = 200000,
    parameter int unsigned BLINK_HALF_CYC = CLK_HZ / 4,
    parameter int unsigned TIMEOUT_CYC    = 30 * CLK_HZ
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                btn_mode_i,
    input  logic                btn_inc_i,
    rtc_set_ctrl_if.master      tbus,
    output logic [3:0]          blank_o,
    output logic [1:0]          state_o
);

    localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BLINK_W = (BLINK_HALF_CYC > 1) ? $clog2(BLINK_HALF_CYC) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);

    logic mode_p, inc_p;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_mode_i),
        .press_o(mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (btn_inc_i),
        .press_o(inc_p)
    );

    state_e             state_q, state_d;
    hours_t             hrs_q, hrs_d;
    mins_t              mins_q, mins_d;
    logic               load_q, load_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               ph_q, ph_d;
    logic               enter;
    logic               timeout;

    always_comb begin
        state_d = state_q;
        hrs_d   = hrs_q;
        mins_d  = mins_q;
        load_d  = 1'b0;
        idle_d  = '0;           // any press or state change restarts idle time
        blink_d = blink_q;
        ph_d    = ph_q;
        enter   = 1'b0;
        timeout = (idle_q == IDLE_LAST);

        // Mode is tested first everywhere, so a simultaneous inc is dropped.
        unique case (state_q)
            ST_RUN: begin
                if (mode_p) begin
                    hrs_d.h10  = tbus.cur_hours_10_i;
                    hrs_d.h1   = tbus.cur_hours_1_i;
                    mins_d.m10 = tbus.cur_min_10_i;
                    mins_d.m1  = tbus.cur_min_1_i;
                    state_d    = ST_SET_HR;
                    enter      = 1'b1;
                end
            end
            ST_SET_HR: begin
                if (mode_p) begin
                    state_d = ST_SET_MIN;
                    enter   = 1'b1;
                end else if (inc_p) begin
                    hrs_d = bcd_inc_hours(hrs_q);
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (mode_p) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (inc_p) begin
                    mins_d = bcd_inc_mins(mins_q);
                end else if (timeout) begin
                    state_d = ST_RUN;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Blink restarts in the visible phase on every entry to a set state.
        if (enter || (state_q == ST_RUN)) begin
            blink_d = '0;
            ph_d    = 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            ph_d    = ~ph_q;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            hrs_q   <= '0;
            mins_q  <= '0;
            load_q  <= 1'b0;
            idle_q  <= '0;
            blink_q <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hrs_q   <= hrs_d;
            mins_q  <= mins_d;
            load_q  <= load_d;
            idle_q  <= idle_d;
            blink_q <= blink_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_SET_HR:  blank_o = {ph_q, ph_q, 2'b00};
            ST_SET_MIN: blank_o = {2'b00, ph_q, ph_q};
            default:    blank_o = 4'b0000;
        endcase
    end

    assign state_o             = state_q;
    assign tbus.set_hours_10_o = hrs_q.h10;
    assign tbus.set_hours_1_o  = hrs_q.h1;
    assign tbus.set_min_10_o   = mins_q.m10;
    assign tbus.set_min_1_o    = mins_q.m1;
    assign tbus.load_o         = load_q;
    // Load leaves the FSM in RUN in the same cycle, so run_en rises with it.
    assign tbus.run_en_o       = (state_q == ST_RUN);

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_set_ctrl
// Directed bench for rtc_set_ctrl with short debounce/blink/timeout periods.
// -----------------------------------------------------------------------------
module tb_rtc_set_ctrl;

    logic clk;
    logic rst_ni;
    logic btn_mode;
    logic btn_inc;
    logic [3:0] blank;
    logic [1:0] state;

    rtc_set_ctrl_if tbus ();

    rtc_set_ctrl #(
        .CLK_HZ        (1000),
        .DEBOUNCE_CYC  (4),
        .BLINK_HALF_CYC(8),
        .TIMEOUT_CYC   (100)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .btn_mode_i(btn_mode),
        .btn_inc_i (btn_inc),
        .tbus      (tbus),
        .blank_o   (blank),
        .state_o   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] set_t;
    assign set_t = {tbus.set_hours_10_o, tbus.set_hours_1_o,
                    tbus.set_min_10_o, tbus.set_min_1_o};

    int n_vec = 0;
    int n_bad = 0;
    int load_cnt = 0;
    logic [13:0] load_t = '0;

    // Each load pulse is seen on exactly one falling edge per cycle high.
    always @(negedge clk) begin
        if (tbus.load_o === 1'b1) begin
            load_cnt = load_cnt + 1;
            load_t   = set_t;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        cyc(10);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cyc(10);
    endtask

    task automatic set_cur(input logic [1:0] h10, input logic [3:0] h1,
                           input logic [3:0] m10, input logic [3:0] m1);
        tbus.cur_hours_10_i = h10;
        tbus.cur_hours_1_i  = h1;
        tbus.cur_min_10_i   = m10;
        tbus.cur_min_1_i    = m1;
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int k;
        k = 0;
        while (state !== st && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {14'd0, state}, {14'd0, st});
    endtask

    initial begin
        int lc0;
        logic [3:0] eb;
        rst_ni   = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        set_cur(2'd1, 4'd2, 4'd3, 4'd4);

        // Reset values
        #3 rst_ni = 1'b0;
        #1;
        chk("rst_state",  {14'd0, state}, 16'd0);
        chk("rst_run_en", {15'd0, tbus.run_en_o}, 16'd1);
        chk("rst_load",   {15'd0, tbus.load_o}, 16'd0);
        chk("rst_blank",  {12'd0, blank}, 16'd0);
        chk("rst_set",    {2'd0, set_t}, 16'd0);
        cyc(3);
        rst_ni = 1'b1;
        cyc(5);

        // Inc in RUN is ignored
        press(1'b0, 1'b1);
        chk("run_inc_state", {14'd0, state}, 16'd0);
        chk("run_inc_set",   {2'd0, set_t}, 16'd0);

        // Mode from 12:34, blink pattern in SET_HR
        btn_mode = 1'b1;
        wait_state(2'd1, "hr_entry");
        chk("hr_run_en", {15'd0, tbus.run_en_o}, 16'd0);
        chk("hr_capture", {2'd0, set_t}, {2'd0, 2'd1, 4'd2, 4'd3, 4'd4});
        for (int i = 0; i <= 16; i++) begin
            if (i == 2) btn_mode = 1'b0;
            eb = (i >= 8 && i < 16) ? 4'b1100 : 4'b0000;
            chk("hr_blink", {12'd0, blank}, {12'd0, eb});
            @(negedge clk);
        end
        cyc(10);

        // inc x2, mode, inc x3, mode -> one load of 14:37
        lc0 = load_cnt;
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("hr_inc2", {2'd0, set_t}, {2'd0, 2'd1, 4'd4, 4'd3, 4'd4});
        press(1'b1, 1'b0);
        chk("to_min", {14'd0, state}, 16'd2);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("min_inc3", {2'd0, set_t}, {2'd0, 2'd1, 4'd4, 4'd3, 4'd7});
        press(1'b1, 1'b0);
        chk("load_once", load_cnt - lc0, 16'd1);
        chk("load_val",  {2'd0, load_t}, {2'd0, 2'd1, 4'd4, 4'd3, 4'd7});
        chk("load_state", {14'd0, state}, 16'd0);
        chk("load_run_en", {15'd0, tbus.run_en_o}, 16'd1);

        // Wraps: 23 -> 00 hours, 59 -> 00 minutes
        set_cur(2'd2, 4'd3, 4'd5, 4'd9);
        press(1'b1, 1'b0);
        chk("cap_2359", {2'd0, set_t}, {2'd0, 2'd2, 4'd3, 4'd5, 4'd9});
        press(1'b0, 1'b1);
        chk("hr_wrap", {2'd0, set_t}, {2'd0, 2'd0, 4'd0, 4'd5, 4'd9});
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        chk("min_wrap", {2'd0, set_t}, {2'd0, 2'd0, 4'd0, 4'd0, 4'd0});
        lc0 = load_cnt;
        press(1'b1, 1'b0);
        chk("wrap_load", load_cnt - lc0, 16'd1);

        // Glitch on inc, then mode+inc together
        set_cur(2'd1, 4'd2, 4'd3, 4'd4);
        press(1'b1, 1'b0);
        chk("g_entry", {14'd0, state}, 16'd1);
        btn_inc = 1'b1;
        cyc(2);
        btn_inc = 1'b0;
        cyc(12);
        chk("glitch_no_inc", {2'd0, set_t}, {2'd0, 2'd1, 4'd2, 4'd3, 4'd4});
        lc0 = load_cnt;
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        wait_state(2'd2, "both_to_min");
        chk("both_hours", {2'd0, set_t}, {2'd0, 2'd1, 4'd2, 4'd3, 4'd4});

        // SET_MIN idle timeout, blink restarted on entry
        for (int k = 0; k <= 100; k++) begin
            if (k == 1) begin
                btn_mode = 1'b0;
                btn_inc  = 1'b0;
            end
            if (k == 0) chk("min_blink0", {12'd0, blank}, 16'd0);
            if (k == 8) chk("min_blink8", {12'd0, blank}, 16'b0011);
            if (k == 99) chk("pre_timeout", {14'd0, state}, 16'd2);
            if (k == 100) begin
                chk("timeout_state", {14'd0, state}, 16'd0);
                chk("timeout_run_en", {15'd0, tbus.run_en_o}, 16'd1);
            end
            @(negedge clk);
        end
        chk("timeout_no_load", load_cnt - lc0, 16'd0);

        // Reset mid-SET_MIN with mode held
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        chk("pre_rst_state", {14'd0, state}, 16'd2);
        lc0 = load_cnt;
        btn_mode = 1'b1;
        cyc(3);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_state",  {14'd0, state}, 16'd0);
        chk("arst_run_en", {15'd0, tbus.run_en_o}, 16'd1);
        chk("arst_load",   {15'd0, tbus.load_o}, 16'd0);
        chk("arst_blank",  {12'd0, blank}, 16'd0);
        chk("arst_set",    {2'd0, set_t}, 16'd0);
        @(negedge clk);
        cyc(2);
        rst_ni = 1'b1;
        cyc(30);
        chk("held_no_press", {14'd0, state}, 16'd0);
        chk("held_no_load", load_cnt - lc0, 16'd0);
        btn_mode = 1'b0;
        cyc(10);
        press(1'b1, 1'b0);
        chk("repress_state", {14'd0, state}, 16'd1);
        chk("repress_set", {2'd0, set_t}, {2'd0, 2'd1, 4'd2, 4'd3, 4'd4});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_set_ctrl.md
RTC_SET_CTRL -- requirements
Module: rtc_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, system clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 200000, cycles a synchronised button level must hold before it is accepted.
REQ-003 SHALL have parameter BLINK_HALF_CYC, default CLK_HZ/4, cycles per blink phase.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 30*CLK_HZ, idle cycles in a set state before abort.
REQ-005 clk_i  in  1  single clock; all flops rising-edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 btn_mode_i  in  1  raw mode button, asynchronous, active-high.
REQ-008 btn_inc_i  in  1  raw increment button, asynchronous, active-high.
REQ-009 cur_hours_10_i  in  2, cur_hours_1_i  in  4, cur_min_10_i  in  4, cur_min_1_i  in  4  live BCD time from the time counter.
REQ-010 set_hours_10_o  out  2, set_hours_1_o  out  4, set_min_10_o  out  4, set_min_1_o  out  4  edited BCD time.
REQ-011 load_o  out  1  one-cycle strobe: counter loads set_* and clears seconds and prescaler.
REQ-012 run_en_o  out  1  counter advance enable.
REQ-013 blank_o  out  4  per-digit blank mask, bit3 = hours_10 ... bit0 = min_1.
REQ-014 state_o  out  2  current FSM state encoding.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser, then debounce: debounced level changes only after DEBOUNCE_CYC consecutive identical synchronised samples.
REQ-016 A press event SHALL be a one-cycle pulse on the 0->1 transition of the debounced level; holding produces no further events.
REQ-017 FSM states: RUN=0, SET_HR=1, SET_MIN=2; state, edit registers and outputs SHALL update on the edge after the press pulse.
REQ-018 RUN + mode press: capture cur_* into edit registers, go SET_HR, run_en_o=0.
REQ-019 SET_HR + inc press: hours +1 in BCD (x9->(x+1)0), 23->00 wrap.
REQ-020 SET_HR + mode press: go SET_MIN.
REQ-021 SET_MIN + inc press: minutes +1 in BCD, 59->00 wrap, hours unchanged.
REQ-022 SET_MIN + mode press: go RUN, load_o=1 for exactly that one cycle, run_en_o=1 in the same cycle.
REQ-023 Mode and inc press in the same cycle: mode SHALL win; inc discarded.
REQ-024 Inc press in RUN SHALL be ignored.
REQ-025 Idle counter SHALL reset on any press event and on entry to a set state; when it reaches TIMEOUT_CYC in SET_HR or SET_MIN, go RUN without load_o, run_en_o=1.
REQ-026 Blink phase SHALL toggle every BLINK_HALF_CYC cycles and restart at "visible" on each state entry.
REQ-027 blank_o: RUN=0000; SET_HR={ph,ph,0,0}; SET_MIN={0,0,ph,ph}; ph=1 during the blanked phase.
REQ-028 set_* SHALL always equal the edit registers; outside the load cycle they are don't-care to the counter.

Reset
REQ-029 Asserting rst_ni SHALL immediately force: state RUN, run_en_o=1, load_o=0, blank_o=0000, set_*=0, debounced levels 0, all counters 0.
REQ-030 Reset mid-edit SHALL discard edits; no load_o is issued on reset release.
REQ-031 A button held through reset release SHALL NOT generate a press event until released and pressed again.

Structure
REQ-032 Package rtc_pkg SHALL hold the state encoding, HR_MAX=23, MIN_MAX=59, and the BCD digit widths.
REQ-033 Sub-module btn_debounce (synchroniser + debounce + edge pulse) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYC=4, BLINK_HALF_CYC=8, TIMEOUT_CYC=100)
REQ-034 cur=12:34, mode press -> state_o=1, run_en_o=0, set=12:34, blank_o toggles 0000/1100 every 8 cycles.
REQ-035 SET_HR from 23, one inc -> set_hours=00; SET_MIN from 59, one inc -> set_min=00, hours unchanged.
REQ-036 Sequence mode, inc x2, mode, inc x3, mode from 12:34 -> single load_o pulse with set=14:37, state_o=0.
REQ-037 In SET_HR, btn_inc_i glitch 2 cycles wide -> no increment; mode+inc same cycle -> SET_MIN, hours unchanged.
REQ-038 SET_MIN idle 100 cycles -> state_o=0, run_en_o=1, load_o never asserted.
REQ-039 rst_ni low mid-SET_MIN with btn_mode_i held -> outputs at reset values asynchronously; no press event until release and re-press.
